// File: rtl/bbtron_seq_pkg.sv
// Shared types and constants for the bbtron multicycle control sequencer:
// FSM states, opcode classes, opcode values, pc_src encodings, ALU codes and
// the bundle of registered control strobes.
package bbtron_seq_pkg;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4,
        S_WAIT_IN  = 3'd5,
        S_WAIT_OUT = 3'd6,
        S_HALT     = 3'd7
    } seq_state_t;

    typedef enum logic [3:0] {
        CLS_NOP     = 4'd0,
        CLS_RALU    = 4'd1,
        CLS_IALU    = 4'd2,
        CLS_LOAD    = 4'd3,
        CLS_STORE   = 4'd4,
        CLS_BEQ     = 4'd5,
        CLS_BNE     = 4'd6,
        CLS_JUMP    = 4'd7,
        CLS_IN      = 4'd8,
        CLS_OUT     = 4'd9,
        CLS_HLT     = 4'd10,
        CLS_ILLEGAL = 4'd11
    } op_class_t;

    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_LOAD  = 6'h20;
    localparam logic [5:0] OP_STORE = 6'h21;
    localparam logic [5:0] OP_BEQ   = 6'h22;
    localparam logic [5:0] OP_BNE   = 6'h23;
    localparam logic [5:0] OP_JUMP  = 6'h24;
    localparam logic [5:0] OP_IN    = 6'h25;
    localparam logic [5:0] OP_OUT   = 6'h26;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    localparam logic [1:0] PC_SRC_NEXT   = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h6;

    // Moore part of the control word; registered as a unit in the top.
    typedef struct packed {
        logic       imem_read;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       alu_src;
        logic       in_select;
        logic       mem_read;
        logic       mem_write;
        logic       in_ready;
        logic       out_valid;
        logic       halted;
        logic [3:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/bbtron_seq_decode.sv
// Stateless opcode decoder: maps the 6-bit opcode to an instruction class
// and the ALU operation that class needs.
module bbtron_seq_decode
    import bbtron_seq_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class,
    output logic [3:0] alu_op
);

    // Classify the opcode and pick its ALU operation.
    always_comb begin
        op_class = CLS_ILLEGAL;
        alu_op   = 4'h0;
        if (opcode == OP_NOP) begin
            op_class = CLS_NOP;
        end else if (opcode[5:4] == 2'b00) begin
            op_class = CLS_RALU;
            alu_op   = opcode[3:0];
        end else if (opcode[5:4] == 2'b01) begin
            op_class = CLS_IALU;
            alu_op   = opcode[3:0];
        end else begin
            case (opcode)
                OP_LOAD: begin
                    op_class = CLS_LOAD;
                    alu_op   = ALU_ADD;
                end
                OP_STORE: begin
                    op_class = CLS_STORE;
                    alu_op   = ALU_ADD;
                end
                OP_BEQ: begin
                    op_class = CLS_BEQ;
                    alu_op   = ALU_SUB;
                end
                OP_BNE: begin
                    op_class = CLS_BNE;
                    alu_op   = ALU_SUB;
                end
                OP_JUMP: op_class = CLS_JUMP;
                OP_IN:   op_class = CLS_IN;
                OP_OUT:  op_class = CLS_OUT;
                OP_HLT:  op_class = CLS_HLT;
                default: op_class = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/bbtron_multicycle_sequencer.sv
// Multicycle control sequencer for the bbtron core. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB (plus WAIT_IN, WAIT_OUT, HALT) and drives
// every datapath enable and mux select. The Moore part of the control word is
// registered from the next-state values; only the branch pc_write (zero) and
// the input-capture reg_write (in_valid) are combined in combinationally.
// Optional performance counters: define BBTRON_SEQ_PERF_EN.
module bbtron_multicycle_sequencer
    import bbtron_seq_pkg::*;
#(
    parameter int IMEM_LAT = 1,
    parameter int DMEM_LAT = 1,
    parameter int ALU_OP_W = 4,
    parameter int PERF_W   = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic                zero,
    input  logic                negative,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                resume,
    output logic                imem_read,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                reg_dest,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic                in_select,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                halted,
    output logic                illegal
`ifdef BBTRON_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0]   cycle_cnt,
    output logic [PERF_W-1:0]   instret_cnt
`endif
);

    localparam logic [1:0] IMEM_LAST = 2'(IMEM_LAT - 1);
    localparam logic [1:0] DMEM_LAST = 2'(DMEM_LAT - 1);

    seq_state_t state_r;
    seq_state_t state_nxt_s;
    logic [1:0] cnt_r;
    logic [1:0] cnt_nxt_s;
    logic [5:0] op_r;
    logic [5:0] op_nxt_s;
    logic       illegal_r;
    logic       illegal_nxt_s;
    ctrl_t      ctrl_r;
    op_class_t  cls_s;
    logic [3:0] dec_alu_s;
    logic       unused_s;

    // The opcode is taken from the IR only while decoding; otherwise the
    // latched copy is used, so cls_s always describes the current instruction.
    assign op_nxt_s = (state_r == S_DECODE) ? opcode : op_r;

    bbtron_seq_decode u_decode (
        .opcode   (op_nxt_s),
        .op_class (cls_s),
        .alu_op   (dec_alu_s)
    );

    // Moore control word for a given state / latency count / class.
    function automatic ctrl_t ctrl_for(input seq_state_t st, input logic [1:0] cnt,
                                       input op_class_t cls, input logic [3:0] alu);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.imem_read = 1'b1;
                if (cnt == IMEM_LAST) begin
                    c.ir_write = 1'b1;
                    c.pc_write = 1'b1;
                    c.pc_src   = PC_SRC_NEXT;
                end else begin
                    c.ir_write = 1'b0;
                end
            end
            S_EXEC: begin
                c.alu_op = alu;
                case (cls)
                    CLS_RALU:                      c.reg_dest = 1'b1;
                    CLS_IALU, CLS_LOAD, CLS_STORE: c.alu_src  = 1'b1;
                    CLS_BEQ, CLS_BNE:              c.pc_src   = PC_SRC_BRANCH;
                    CLS_JUMP: begin
                        c.pc_write = 1'b1;
                        c.pc_src   = PC_SRC_JUMP;
                    end
                    default:                       c.alu_src  = 1'b0;
                endcase
            end
            S_MEM: begin
                c.alu_op  = alu;
                c.alu_src = 1'b1;
                if (cls == CLS_LOAD) begin
                    c.mem_read = 1'b1;
                end else begin
                    c.mem_write = 1'b1;
                end
            end
            S_WB: begin
                c.alu_op     = alu;
                c.reg_write  = 1'b1;
                c.mem_to_reg = (cls == CLS_LOAD);
                c.reg_dest   = (cls == CLS_RALU);
                c.alu_src    = (cls == CLS_IALU);
            end
            S_WAIT_IN: begin
                c.in_ready  = 1'b1;
                c.in_select = 1'b1;
            end
            S_WAIT_OUT: c.out_valid = 1'b1;
            S_HALT:     c.halted    = 1'b1;
            default:    c.imem_read = 1'b0;
        endcase
        return c;
    endfunction

    // Next-state, latency-counter and sticky-illegal logic.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        illegal_nxt_s = illegal_r;
        case (state_r)
            S_FETCH: begin
                if (cnt_r == IMEM_LAST) begin
                    cnt_nxt_s   = 2'd0;
                    state_nxt_s = S_DECODE;
                end else begin
                    cnt_nxt_s = cnt_r + 2'd1;
                end
            end
            S_DECODE: begin
                case (cls_s)
                    CLS_NOP: state_nxt_s = S_FETCH;
                    CLS_RALU, CLS_IALU, CLS_LOAD, CLS_STORE,
                    CLS_BEQ, CLS_BNE, CLS_JUMP: state_nxt_s = S_EXEC;
                    CLS_IN:  state_nxt_s = S_WAIT_IN;
                    CLS_OUT: state_nxt_s = S_WAIT_OUT;
                    CLS_HLT: state_nxt_s = S_HALT;
                    default: begin
                        state_nxt_s   = S_FETCH;
                        illegal_nxt_s = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                case (cls_s)
                    CLS_LOAD, CLS_STORE: state_nxt_s = S_MEM;
                    CLS_RALU, CLS_IALU:  state_nxt_s = S_WB;
                    default:             state_nxt_s = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (cnt_r == DMEM_LAST) begin
                    cnt_nxt_s   = 2'd0;
                    state_nxt_s = (cls_s == CLS_LOAD) ? S_WB : S_FETCH;
                end else begin
                    cnt_nxt_s = cnt_r + 2'd1;
                end
            end
            S_WB: state_nxt_s = S_FETCH;
            S_WAIT_IN: begin
                if (in_valid) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_WAIT_IN;
                end
            end
            S_WAIT_OUT: begin
                if (out_ready) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_WAIT_OUT;
                end
            end
            S_HALT: begin
                if (resume) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_HALT;
                end
            end
            default: begin
                state_nxt_s = S_FETCH;
                cnt_nxt_s   = 2'd0;
            end
        endcase
    end

    // Sequencer state, latched opcode and registered Moore control word.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= S_FETCH;
            cnt_r     <= 2'd0;
            op_r      <= 6'h00;
            illegal_r <= 1'b0;
            ctrl_r    <= ctrl_for(S_FETCH, 2'd0, CLS_NOP, 4'h0);
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            op_r      <= op_nxt_s;
            illegal_r <= illegal_nxt_s;
            ctrl_r    <= ctrl_for(state_nxt_s, cnt_nxt_s, cls_s, dec_alu_s);
        end
    end

    assign imem_read  = ctrl_r.imem_read;
    assign ir_write   = ctrl_r.ir_write;
    assign pc_write   = ctrl_r.pc_write
                      | ((state_r == S_EXEC) && (cls_s == CLS_BEQ) && zero)
                      | ((state_r == S_EXEC) && (cls_s == CLS_BNE) && !zero);
    assign pc_src     = ctrl_r.pc_src;
    assign reg_write  = ctrl_r.reg_write | ((state_r == S_WAIT_IN) && in_valid);
    assign reg_dest   = ctrl_r.reg_dest;
    assign mem_to_reg = ctrl_r.mem_to_reg;
    assign alu_src    = ctrl_r.alu_src;
    assign in_select  = ctrl_r.in_select;
    assign mem_read   = ctrl_r.mem_read;
    assign mem_write  = ctrl_r.mem_write;
    assign in_ready   = ctrl_r.in_ready;
    assign out_valid  = ctrl_r.out_valid;
    assign halted     = ctrl_r.halted;
    assign alu_op     = ALU_OP_W'(ctrl_r.alu_op);
    assign illegal    = illegal_r;

`ifdef BBTRON_SEQ_PERF_EN
    logic [PERF_W-1:0] cycle_cnt_r;
    logic [PERF_W-1:0] instret_cnt_r;

    // Cycle counter (frozen in HALT) and retired-instruction counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_cnt_r   <= '0;
            instret_cnt_r <= '0;
        end else begin
            if (state_r != S_HALT) begin
                cycle_cnt_r <= cycle_cnt_r + PERF_W'(1);
            end
            if ((state_nxt_s == S_FETCH) && (state_r != S_FETCH)) begin
                instret_cnt_r <= instret_cnt_r + PERF_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_r;
    assign instret_cnt = instret_cnt_r;
    assign unused_s    = negative;
`else
    assign unused_s    = negative ^ (PERF_W == 0);
`endif

endmodule

// File: tb/tb_bbtron_multicycle_sequencer.sv
// Directed scoreboard bench for bbtron_multicycle_sequencer (IMEM_LAT=2,
// DMEM_LAT=2). Each step pushes its inputs and the expected control word;
// the drain task applies them cycle by cycle and compares.
module tb_bbtron_multicycle_sequencer;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic       zero, negative, in_valid, out_ready, resume;
    logic       in_ready, out_valid, imem_read, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, reg_dest, mem_to_reg, alu_src, in_select;
    logic       mem_read, mem_write, halted, illegal;
    logic [3:0] alu_op;
`ifdef BBTRON_SEQ_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    bbtron_multicycle_sequencer #(
        .IMEM_LAT (2),
        .DMEM_LAT (2),
        .ALU_OP_W (4),
        .PERF_W   (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .negative   (negative),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .resume     (resume),
        .imem_read  (imem_read),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .reg_dest   (reg_dest),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .in_select  (in_select),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_op     (alu_op),
        .halted     (halted),
        .illegal    (illegal)
`ifdef BBTRON_SEQ_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [19:0] IMR   = 20'h00001;
    localparam logic [19:0] IRW   = 20'h00002;
    localparam logic [19:0] PCW   = 20'h00004;
    localparam logic [19:0] PCS1  = 20'h00008;
    localparam logic [19:0] PCS2  = 20'h00010;
    localparam logic [19:0] RW    = 20'h00020;
    localparam logic [19:0] RD    = 20'h00040;
    localparam logic [19:0] M2R   = 20'h00080;
    localparam logic [19:0] ASRC  = 20'h00100;
    localparam logic [19:0] INSEL = 20'h00200;
    localparam logic [19:0] MRD   = 20'h00400;
    localparam logic [19:0] MWR   = 20'h00800;
    localparam logic [19:0] IRDY  = 20'h01000;
    localparam logic [19:0] OVLD  = 20'h02000;
    localparam logic [19:0] HLT   = 20'h04000;
    localparam logic [19:0] ILL   = 20'h08000;
    localparam logic [19:0] F1    = IMR;
    localparam logic [19:0] F2    = IMR | IRW | PCW;
    localparam logic [19:0] DEC   = 20'h00000;

    function automatic logic [19:0] aop(input logic [3:0] v);
        return {v, 16'h0000};
    endfunction

    logic [19:0] observed;
    assign observed = {alu_op, illegal, halted, out_valid, in_ready, mem_write, mem_read,
                       in_select, alu_src, mem_to_reg, reg_dest, reg_write, pc_src,
                       pc_write, ir_write, imem_read};

    typedef struct {
        string       tag;
        logic [5:0]  op;
        logic        z;
        logic        iv;
        logic        ordy;
        logic        res;
        logic        rst_n;
        logic [19:0] exp;
    } step_t;

    step_t sq[$];
    int compared   = 0;
    int mismatched = 0;

    logic [5:0] cur_op   = 6'h00;
    logic       cur_z    = 1'b0;
    logic       cur_iv   = 1'b0;
    logic       cur_ordy = 1'b0;
    logic       cur_res  = 1'b0;
    logic       cur_rst  = 1'b0;
    logic       cur_ill  = 1'b0;

    function automatic void push(input string tag, input logic [19:0] e);
        step_t s;
        s.tag   = tag;
        s.op    = cur_op;
        s.z     = cur_z;
        s.iv    = cur_iv;
        s.ordy  = cur_ordy;
        s.res   = cur_res;
        s.rst_n = cur_rst;
        s.exp   = e | (cur_ill ? ILL : 20'h00000);
        sq.push_back(s);
    endfunction

    task automatic drain();
        step_t s;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            opcode    = s.op;
            zero      = s.z;
            in_valid  = s.iv;
            out_ready = s.ordy;
            resume    = s.res;
            reset     = s.rst_n;
            #1;
            compared++;
            assert (observed === s.exp) else begin
                mismatched++;
                $error("FAIL %s observed=%05h expected=%05h", s.tag, observed, s.exp);
            end
            @(posedge clock);
            #2;
        end
    endtask

    task automatic front(input string tag);
        push({tag, "_f1"}, F1);
        push({tag, "_f2"}, F2);
        push({tag, "_dec"}, DEC);
    endtask

    initial begin
        reset = 1'b0; opcode = 6'h00; zero = 1'b0; negative = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; resume = 1'b0;
        @(posedge clock);
        #2;

        cur_rst = 1'b0;
        push("reset0", IMR);
        push("reset1", IMR);
        drain();
        cur_rst = 1'b1;

        cur_op = 6'h01; front("ralu");
        push("ralu_exec", RD | aop(4'h1));
        push("ralu_wb", RW | RD | aop(4'h1));
        drain();

        cur_op = 6'h13; front("ialu");
        push("ialu_exec", ASRC | aop(4'h3));
        push("ialu_wb", RW | ASRC | aop(4'h3));
        drain();

        cur_op = 6'h20; front("load");
        push("load_exec", ASRC | aop(4'h2));
        push("load_mem0", ASRC | MRD | aop(4'h2));
        push("load_mem1", ASRC | MRD | aop(4'h2));
        push("load_wb", RW | M2R | aop(4'h2));
        drain();

        cur_op = 6'h21; front("store");
        push("store_exec", ASRC | aop(4'h2));
        push("store_mem0", ASRC | MWR | aop(4'h2));
        push("store_mem1", ASRC | MWR | aop(4'h2));
        drain();

        cur_op = 6'h22; front("beq_t");
        cur_z = 1'b1; push("beq_t_exec", PCW | PCS1 | aop(4'h6)); cur_z = 1'b0;
        front("beq_n");
        push("beq_n_exec", PCS1 | aop(4'h6));
        cur_op = 6'h23; front("bne_t");
        push("bne_t_exec", PCW | PCS1 | aop(4'h6));
        front("bne_n");
        cur_z = 1'b1; push("bne_n_exec", PCS1 | aop(4'h6)); cur_z = 1'b0;
        drain();

        cur_op = 6'h24; front("jump");
        push("jump_exec", PCW | PCS2);
        cur_op = 6'h00; front("nop");
        drain();

        cur_op = 6'h25; front("in");
        for (int i = 0; i < 5; i++) push("in_wait", IRDY | INSEL);
        cur_iv = 1'b1; push("in_take", IRDY | INSEL | RW);
        drain();

        cur_op = 6'h26; front("out_ivhigh");
        cur_iv = 1'b0;
        for (int i = 0; i < 3; i++) push("out_stall", OVLD);
        cur_ordy = 1'b1; push("out_take", OVLD);
        drain();
        cur_ordy = 1'b0;

        cur_op = 6'h3F; cur_res = 1'b1; front("hlt_resume_ignored");
        cur_res = 1'b0;
        for (int i = 0; i < 10; i++) push("halt_hold", HLT);
        cur_res = 1'b1; push("halt_resume", HLT);
        cur_res = 1'b0; cur_op = 6'h00;
        push("after_resume_f1", F1);
        drain();

        cur_op = 6'h30;
        push("ill_f2", F2);
        push("ill_dec", DEC);
        cur_ill = 1'b1;
        cur_op = 6'h00; front("ill_sticky");
        cur_op = 6'h3F; front("hlt2");
        push("hlt2_hold", HLT);
        cur_rst = 1'b0; cur_res = 1'b1; push("hlt2_reset_resume", HLT);
        drain();
        cur_rst = 1'b1; cur_res = 1'b0; cur_ill = 1'b0;

        cur_op = 6'h21; front("st_rst");
        push("st_rst_exec", ASRC | aop(4'h2));
        cur_rst = 1'b0; push("st_rst_mem0", ASRC | MWR | aop(4'h2));
        cur_rst = 1'b1; cur_op = 6'h00;
        push("st_rst_after", F1);
        push("st_rst_f2", F2);
        push("st_rst_dec", DEC);
        push("st_rst_next", F1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
